// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard control bundle: hazard/memory inputs from the datapath,
// stall/flush/status outputs back to the pipeline registers.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rd_e;
  logic             load_e;
  logic             pc_src_e;
  logic             dmem_req_m;
  logic             dmem_ready;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic             mem_busy;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_d, rs2_d, rd_e, load_e, pc_src_e, dmem_req_m, dmem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           mem_busy, mem_timeout, stall_cycles
  );

  modport slave (
    input  rs1_d, rs2_d, rd_e, load_e, pc_src_e, dmem_req_m, dmem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           mem_busy, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush generation for the 5-stage core: load-use, taken branch and
// data-memory wait states, with a sticky timeout and a stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic {IDLE, MEM_WAIT} state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] sc_q, sc_d;

  logic mem_stall, lw_stall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  always_comb begin
    mem_stall = ((state_q == IDLE) && hz.dmem_req_m && !hz.dmem_ready) ||
                ((state_q == MEM_WAIT) && !hz.dmem_ready);
    lw_stall  = hz.load_e && (hz.rd_e != 5'd0) &&
                ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
  end

  // Memory stall freezes EX, so any branch/load-use there is simply retried
  // once memory releases the pipe.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        flush_d = hz.pc_src_e;
      end else begin
        flush_d = hz.pc_src_e;
        flush_e = hz.pc_src_e;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    sc_d       = sc_q;
    case (state_q)
      IDLE: begin
        if (hz.dmem_req_m && !hz.dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d = IDLE;
        end else if (wait_cnt_q != TIMEOUT_C) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // wait_cnt only reaches TIMEOUT by counting refused MEM_WAIT cycles
    tmo_d = tmo_q || (wait_cnt_d == TIMEOUT_C);
    if (stall_f && (sc_q != '1)) sc_d = sc_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      tmo_q      <= 1'b0;
      sc_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_q      <= tmo_d;
      sc_q       <= sc_d;
    end
  end

  assign hz.stall_f      = stall_f;
  assign hz.stall_d      = stall_d;
  assign hz.stall_e      = stall_e;
  assign hz.stall_m      = stall_m;
  assign hz.flush_d      = flush_d;
  assign hz.flush_e      = flush_e;
  assign hz.flush_w      = flush_w;
  assign hz.mem_busy     = (state_q == MEM_WAIT);
  assign hz.mem_timeout  = tmo_q;
  assign hz.stall_cycles = sc_q;

endmodule
